register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 94 +++++++++
 tb/tb_register_file.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Multi-port register file: two combinational read ports with write-first bypass,
// one synchronous write port, plus debug tracking of committed writes.
module register_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [7:0]        writeCount,
    output logic [ADDR_W-1:0] lastWriteReg
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [7:0]        count_q;
    logic [7:0]        count_d;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] last_d;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    // Reset gates the bypass path too, so reads are forced to zero while held in reset.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_ok,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_idx,
        input logic [DATA_W-1:0] wr_data,
        input logic [ADDR_W-1:0] rd_idx,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (!rst_ok) begin
            val = {DATA_W{1'b0}};
        end else if (wr_en && (wr_idx == rd_idx)) begin
            val = wr_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Next-state for storage and debug counters on a committed write.
    always_comb begin
        regs_d  = regs_q;
        count_d = count_q;
        last_d  = last_q;
        if (regWrite) begin
            regs_d[writeReg] = writeData;
            count_d          = count_q + 8'd1;
            last_d           = writeReg;
        end else begin
            count_d = count_q;
            last_d  = last_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            count_q <= 8'd0;
            last_q  <= {ADDR_W{1'b0}};
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Combinational read ports, each bypassing independently.
    always_comb begin
        rd1_s = read_port(reset_n, regWrite, writeReg, writeData, readReg1, regs_q[readReg1]);
        rd2_s = read_port(reset_n, regWrite, writeReg, writeData, readReg2, regs_q[readReg2]);
    end

    assign readData1    = rd1_s;
    assign readData2    = rd2_s;
    assign writeCount   = count_q;
    assign lastWriteReg = last_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file at default parameters.
module tb_register_file;

    logic       clk;
    logic       reset_n;
    logic       regWrite;
    logic [1:0] writeReg;
    logic [7:0] writeData;
    logic [1:0] readReg1;
    logic [1:0] readReg2;
    logic [7:0] readData1;
    logic [7:0] readData2;
    logic [7:0] writeCount;
    logic [1:0] lastWriteReg;

    int n_cmp;
    int n_err;

    register_file #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .readReg1     (readReg1),
        .readReg2     (readReg2),
        .readData1    (readData1),
        .readData2    (readData2),
        .writeCount   (writeCount),
        .lastWriteReg (lastWriteReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        regWrite  = 1'b1;
        writeReg  = addr;
        writeData = data;
        @(posedge clk);
        #1;
        regWrite  = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        regWrite  = 1'b0;
        writeReg  = 2'd0;
        writeData = 8'd0;
        readReg1  = 2'd0;
        readReg2  = 2'd1;
        #2;
        chk("rst_rd1", readData1, 8'h00);
        chk("rst_rd2", readData2, 8'h00);
        chk("rst_cnt", writeCount, 8'h00);
        chk("rst_last", {6'd0, lastWriteReg}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic writes then reads
        do_write(2'd1, 8'hA5);
        do_write(2'd2, 8'h3C);
        readReg1 = 2'd1;
        readReg2 = 2'd2;
        #1;
        chk("basic_rd1", readData1, 8'hA5);
        chk("basic_rd2", readData2, 8'h3C);
        chk("basic_cnt", writeCount, 8'd2);
        chk("basic_last", {6'd0, lastWriteReg}, 8'd2);

        // Bypass on both ports
        do_write(2'd3, 8'h11);
        @(negedge clk);
        readReg1  = 2'd3;
        readReg2  = 2'd3;
        regWrite  = 1'b1;
        writeReg  = 2'd3;
        writeData = 8'h77;
        #1;
        chk("byp_rd1", readData1, 8'h77);
        chk("byp_rd2", readData2, 8'h77);
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        #1;
        chk("byp_after_rd1", readData1, 8'h77);
        chk("byp_cnt", writeCount, 8'd4);
        chk("byp_last", {6'd0, lastWriteReg}, 8'd3);

        // No write while regWrite=0
        @(negedge clk);
        regWrite  = 1'b0;
        writeReg  = 2'd1;
        writeData = 8'hFF;
        readReg1  = 2'd1;
        readReg2  = 2'd1;
        repeat (5) @(posedge clk);
        #1;
        chk("nowr_rd1", readData1, 8'hA5);
        chk("same_rd2", readData2, 8'hA5);
        chk("nowr_cnt", writeCount, 8'd4);
        chk("nowr_last", {6'd0, lastWriteReg}, 8'd3);

        // Rewriting the same value still counts
        do_write(2'd1, 8'hA5);
        chk("same_val_cnt", writeCount, 8'd5);
        chk("same_val_last", {6'd0, lastWriteReg}, 8'd1);

        // Fill r0, then async reset mid-cycle with a concurrent write attempt
        do_write(2'd0, 8'h5A);
        readReg1 = 2'd0;
        readReg2 = 2'd3;
        #1;
        chk("r0_rd1", readData1, 8'h5A);
        chk("pre_cnt", writeCount, 8'd6);
        @(negedge clk);
        #2;
        reset_n   = 1'b0;
        regWrite  = 1'b1;
        writeReg  = 2'd0;
        writeData = 8'h99;
        #1;
        chk("arst_rd1", readData1, 8'h00);
        chk("arst_rd2", readData2, 8'h00);
        chk("arst_cnt", writeCount, 8'h00);
        chk("arst_last", {6'd0, lastWriteReg}, 8'h00);
        readReg2 = 2'd0;
        #1;
        chk("arst_nobyp", readData2, 8'h00);
        @(posedge clk);
        #1;
        chk("arst_wr_cnt", writeCount, 8'h00);
        @(negedge clk);
        regWrite = 1'b0;
        reset_n  = 1'b1;
        readReg1 = 2'd0;
        readReg2 = 2'd1;
        #1;
        chk("post_r0", readData1, 8'h00);
        chk("post_r1", readData2, 8'h00);
        readReg1 = 2'd2;
        readReg2 = 2'd3;
        #1;
        chk("post_r2", readData1, 8'h00);
        chk("post_r3", readData2, 8'h00);
        chk("post_cnt", writeCount, 8'h00);

        // First write after release commits
        do_write(2'd2, 8'hC3);
        chk("first_rd1", readData1, 8'hC3);
        chk("first_cnt", writeCount, 8'd1);
        chk("first_last", {6'd0, lastWriteReg}, 8'd2);

        // Counter wrap over 256 writes from reset
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            do_write(2'(i), 8'(i));
            if (i == 254) begin
                chk("wrap_255", writeCount, 8'd255);
            end
        end
        readReg1 = 2'd3;
        readReg2 = 2'd2;
        #1;
        chk("wrap_256", writeCount, 8'd0);
        chk("wrap_last", {6'd0, lastWriteReg}, 8'd3);
        chk("wrap_r3", readData1, 8'hFF);
        chk("wrap_r2", readData2, 8'hFE);
        do_write(2'd0, 8'h01);
        chk("wrap_257", writeCount, 8'd1);
        chk("wrap_257_last", {6'd0, lastWriteReg}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
